// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
package seq_adder_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // At least one index bit so a single-chunk build still has a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Start/busy/done handshake and operand/result bus of seq_chunk_adder.
// SEQ_CHUNK_ADDER_SUB_EN adds the i_sub request bit.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 16
);
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_carry_in;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic             i_sub;
`endif
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_sum;
  logic             o_carry;
  logic             o_overflow;

  modport master (
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    output i_sub,
`endif
    output i_start, i_a, i_b, i_carry_in,
    input  o_busy, o_done, o_sum, o_carry, o_overflow
  );

  modport slave (
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  i_sub,
`endif
    input  i_start, i_a, i_b, i_carry_in,
    output o_busy, o_done, o_sum, o_carry, o_overflow
  );
endinterface

// File: rtl/ripple_adder_n.sv
// Combinational N-bit ripple-carry adder; also exposes the carry into the MSB.
module ripple_adder_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_c,
  output logic [N-1:0] o_sum,
  output logic         o_carry,
  output logic         o_carry_msb_in
);
  logic [N:0] c;

  always_comb begin
    c     = '0;
    o_sum = '0;
    c[0]  = i_c;
    for (int unsigned i = 0; i < N; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ c[i];
      c[i+1]    = (i_a[i] & i_b[i]) | (c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_carry        = c[N];
  assign o_carry_msb_in = c[N-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock with a registered carry.
// Define SEQ_CHUNK_ADDER_SUB_EN to enable subtraction via bus.i_sub.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  seq_chunk_adder_if.slave bus
);
  localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
  localparam int IDX_W      = idx_width(NUM_CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, psum_q, psum_d, sum_q, sum_d;
  logic             c_q, c_d, carry_q, carry_d, ovf_q, ovf_d, done_q, done_d;

  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
  logic             chunk_cout, chunk_msb_in;

  always_comb begin
    chunk_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
    chunk_b = b_q[int'(idx_q)*CHUNK +: CHUNK];
  end

  ripple_adder_n #(.N(CHUNK)) u_chunk (
    .i_a            (chunk_a),
    .i_b            (chunk_b),
    .i_c            (c_q),
    .o_sum          (chunk_sum),
    .o_carry        (chunk_cout),
    .o_carry_msb_in (chunk_msb_in)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          a_d = bus.i_a;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
          // A + ~B + cin == A - B - !cin
          b_d = bus.i_sub ? ~bus.i_b : bus.i_b;
`else
          b_d = bus.i_b;
`endif
          c_d     = bus.i_carry_in;
          psum_d  = '0;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        psum_d[int'(idx_q)*CHUNK +: CHUNK] = chunk_sum;
        c_d   = chunk_cout;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          sum_d   = psum_d;
          carry_d = chunk_cout;
          ovf_d   = chunk_cout ^ chunk_msb_in;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_busy     = (state_q == ST_RUN);
  assign bus.o_done     = done_q;
  assign bus.o_sum      = sum_q;
  assign bus.o_carry    = carry_q;
  assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder (WIDTH=16, CHUNK=4).
module tb_seq_chunk_adder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_chunk_adder_if #(.WIDTH(16)) bus ();

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive start at a falling edge; returns #1 after the accepting edge.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic cin);
    @(negedge clk);
    bus.i_a        = a;
    bus.i_b        = b;
    bus.i_carry_in = cin;
    bus.i_start    = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  // Counts edges from the accepting edge to the done cycle, and busy samples.
  task automatic wait_done(input string tag, output int edges, output int busy_n);
    edges  = 0;
    busy_n = bus.o_busy ? 1 : 0;
    while (!bus.o_done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.o_busy) busy_n++;
    end
    check({tag, "_done_seen"}, {31'd0, bus.o_done}, 32'd1);
  endtask

  task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [15:0] es, input logic ec, input logic ev);
    int e, bn;
    launch(a, b, cin);
    wait_done(tag, e, bn);
    check({tag, "_sum"},  {16'd0, bus.o_sum}, {16'd0, es});
    check({tag, "_cout"}, {31'd0, bus.o_carry}, {31'd0, ec});
    check({tag, "_ovf"},  {31'd0, bus.o_overflow}, {31'd0, ev});
    check({tag, "_lat"},  e, 4);
  endtask

  initial begin
    int e, bn;
    checks = 0;
    errors = 0;
    rst            = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_a        = '0;
    bus.i_b        = '0;
    bus.i_carry_in = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    bus.i_sub      = 1'b0;
`endif
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum",  {16'd0, bus.o_sum}, 32'd0);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_done", {31'd0, bus.o_done}, 32'd0);
    check("rst_cout", {31'd0, bus.o_carry}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic add with latency, busy width and done pulse width
    launch(16'h1234, 16'h4321, 1'b0);
    wait_done("basic", e, bn);
    check("basic_sum",  {16'd0, bus.o_sum}, 32'h5555);
    check("basic_cout", {31'd0, bus.o_carry}, 32'd0);
    check("basic_ovf",  {31'd0, bus.o_overflow}, 32'd0);
    check("basic_lat",  e, 4);
    check("basic_busy", bn, 4);
    @(posedge clk);
    #1;
    check("basic_done_1cyc", {31'd0, bus.o_done}, 32'd0);

    run_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_add("sovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_add("both",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_add("cin",    16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);

    // Start while busy is ignored; operand changes mid-run have no effect
    launch(16'h0001, 16'h0001, 1'b0);
    bus.i_a     = 16'hAAAA;
    bus.i_b     = 16'h5555;
    bus.i_start = 1'b1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    check("hold_sum_midrun", {16'd0, bus.o_sum}, 32'h0100);
    wait_done("busy_ign", e, bn);
    check("busy_ign_sum", {16'd0, bus.o_sum}, 32'h0002);
    check("busy_ign_lat", e + 1, 4);

    // Restart in the done cycle
    launch(16'h0003, 16'h0004, 1'b0);
    check("b2b_busy", {31'd0, bus.o_busy}, 32'd1);
    check("b2b_hold", {16'd0, bus.o_sum}, 32'h0002);
    wait_done("b2b", e, bn);
    check("b2b_sum", {16'd0, bus.o_sum}, 32'h0007);
    check("b2b_lat", e, 4);

    // Reset during the second RUN cycle
    @(posedge clk);
    #1;
    launch(16'h1111, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mrst_sum",  {16'd0, bus.o_sum}, 32'd0);
    check("mrst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("mrst_done", {31'd0, bus.o_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bn = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.o_done) bn++;
    end
    check("mrst_no_done", bn, 0);
    run_add("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    bus.i_sub = 1'b1;
    run_add("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_add("sub_pos", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    bus.i_sub = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
